// File: rtl/bsg_gateway_tag_cmd_if.sv
// Command handshake between the gateway tag front-end and the tag master.
// Master side drives a command plus valid; slave side returns ready.
interface bsg_gateway_tag_cmd_if;
  logic       v_o;
  logic       ready_i;
  logic [2:0] clk_id_o;
  logic [4:0] osc_o;
  logic [7:0] div_o;
  logic       isDiv_o;
  logic       clk_reset_o;

  modport master (
    output v_o,
    output clk_id_o,
    output osc_o,
    output div_o,
    output isDiv_o,
    output clk_reset_o,
    input  ready_i
  );

  modport slave (
    input  v_o,
    input  clk_id_o,
    input  osc_o,
    input  div_o,
    input  isDiv_o,
    input  clk_reset_o,
    output ready_i
  );
endinterface

// File: rtl/bsg_gateway_tag_cmd.sv
// Gateway tag command front-end: GPIO toggle decode, command FIFO, status.
// Optional: define BSG_GATEWAY_TAG_CMD_PARITY_EN to check even parity on gpio[31].
module bsg_gateway_tag_cmd #(
  parameter int num_clk_p   = 6,
  parameter int fifo_els_p  = 4,
  parameter int cnt_width_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [31:0]                  gpio_i,
  bsg_gateway_tag_cmd_if.master        cmd_if,
  output logic                         busy_o,
  output logic [31:0]                  status_o
);

  localparam int PtrW = $clog2(fifo_els_p);
  localparam int CntW = $clog2(fifo_els_p + 1);
  localparam logic [31:0] NumClk = 32'(num_clk_p);
  localparam logic [CntW-1:0] Depth = CntW'(fifo_els_p);

  // {rst, isDiv, div[7:0], osc[4:0], clk_id[2:0]}
  typedef logic [17:0] cmd_t;

  logic [31:0]            r_gpio;
  logic                   r_primed;
  logic                   r_toggle_ref;
  cmd_t                   r_mem [fifo_els_p];
  logic [PtrW-1:0]        r_wr;
  logic [PtrW-1:0]        r_rd;
  logic [CntW-1:0]        r_count;
  logic [cnt_width_p-1:0] r_drop;
  logic [cnt_width_p-1:0] r_ovf;
  logic [31:0]            r_status;

  logic        w_recog;
  logic        w_legal;
  logic        w_par_ok;
  logic        w_accept;
  logic        w_drop;
  logic        w_full;
  logic        w_v;
  logic        w_pop;
  logic        w_push;
  logic        w_ovf;
  logic [31:0] w_status;
  cmd_t        w_head;
  logic        w_unused;

  assign w_recog  = r_primed & (r_gpio[0] ^ r_toggle_ref);
  assign w_legal  = {29'b0, r_gpio[3:1]} < NumClk;

`ifdef BSG_GATEWAY_TAG_CMD_PARITY_EN
  assign w_par_ok = ~(^r_gpio);
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_unused = ^r_gpio[31:19];

  assign w_accept = w_recog & w_legal & w_par_ok;
  assign w_drop   = w_recog & ~(w_legal & w_par_ok);
  assign w_full   = (r_count == Depth);
  assign w_v      = (r_count != '0);
  assign w_pop    = w_v & cmd_if.ready_i;
  assign w_push   = w_accept & (~w_full | w_pop);
  assign w_ovf    = w_accept & w_full & ~w_pop;
  assign w_head   = r_mem[r_rd];

  assign cmd_if.v_o         = w_v;
  assign cmd_if.clk_id_o    = w_head[2:0];
  assign cmd_if.osc_o       = w_head[7:3];
  assign cmd_if.div_o       = w_head[15:8];
  assign cmd_if.isDiv_o     = w_head[16];
  assign cmd_if.clk_reset_o = w_head[17];

  assign busy_o   = w_v;
  assign status_o = r_status;

  // Capture GPIO even in reset so priming sees the word firmware left behind
  always_ff @(posedge clk_i) begin
    r_gpio <= gpio_i;
  end

  // Toggle tracking; first cycle out of reset only primes the reference
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_primed     <= 1'b0;
      r_toggle_ref <= 1'b0;
    end else begin
      r_primed     <= 1'b1;
      r_toggle_ref <= r_gpio[0];
    end
  end

  // Command FIFO storage and pointers; simultaneous push and pop allowed
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < fifo_els_p; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= r_gpio[18:1];
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  // Saturating drop and overflow counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_drop <= '0;
      r_ovf  <= '0;
    end else begin
      if (w_drop && r_drop != '1) r_drop <= r_drop + 1'b1;
      if (w_ovf && r_ovf != '1)   r_ovf  <= r_ovf + 1'b1;
    end
  end

  // Pack status fields LSB-aligned: count, then ovf at 8, then drop
  always_comb begin
    w_status = '0;
    w_status[CntW-1:0] = r_count;
    w_status[8 +: cnt_width_p] = r_ovf;
    w_status[8+cnt_width_p +: cnt_width_p] = r_drop;
  end

  // Status is registered, so it trails the live state by one edge
  always_ff @(posedge clk_i) begin
    if (reset_i) r_status <= '0;
    else         r_status <= w_status;
  end

endmodule

// File: tb/tb_bsg_gateway_tag_cmd.sv
// Directed bench for bsg_gateway_tag_cmd: vector table plus corner sequences.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_bsg_gateway_tag_cmd;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] gpio;
  logic        busy;
  logic [31:0] status;

  bsg_gateway_tag_cmd_if cif ();

  bsg_gateway_tag_cmd dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .gpio_i   (gpio),
    .cmd_if   (cif.master),
    .busy_o   (busy),
    .status_o (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  id;
    logic [4:0]  osc;
    logic [7:0]  div;
    logic        isd;
    logic        rst;
    logic [11:0] rsv;
    logic        legal;
  } vec_t;

  vec_t vecs [6];
  int   n_run  = 0;
  int   n_fail = 0;
  logic tog;
  int   exp_drop;
  int   vc;
  logic [2:0] exp_ids [4];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input vec_t v, input logic t,
                                     input logic badpar);
    logic [31:0] w;
    w = {1'b0, v.rsv, v.rst, v.isd, v.div, v.osc, v.id, t};
    w[31] = (^w[30:0]) ^ badpar;
    return w;
  endfunction

  function automatic logic [31:0] stat(input int d, input int o, input int c);
    logic [7:0] d8, o8;
    logic [3:0] c4;
    d8 = d[7:0];
    o8 = o[7:0];
    c4 = c[3:0];
    return {8'h00, d8, o8, 4'h0, c4};
  endfunction

  function automatic vec_t mkv(input logic [2:0] id);
    vec_t v;
    v = '{id: id, osc: 5'h04, div: 8'h21, isd: 1'b0, rst: 1'b0,
          rsv: 12'h0, legal: 1'b1};
    return v;
  endfunction

  // One toggle with ready high and an empty FIFO: checks the 2-cycle window
  task automatic send(input vec_t v, input logic badpar);
    logic ok;
    tog  = ~tog;
    gpio = mk(v, tog, badpar);
    ok   = v.legal & ~badpar;
    @(negedge clk);
    chk("lat1_v", {31'b0, cif.v_o}, 32'h0);
    @(negedge clk);
    chk("lat2_v", {31'b0, cif.v_o}, {31'b0, ok});
    if (ok) begin
      chk("clk_id", {29'b0, cif.clk_id_o}, {29'b0, v.id});
      chk("osc", {27'b0, cif.osc_o}, {27'b0, v.osc});
      chk("div", {24'b0, cif.div_o}, {24'b0, v.div});
      chk("isDiv", {31'b0, cif.isDiv_o}, {31'b0, v.isd});
      chk("clk_reset", {31'b0, cif.clk_reset_o}, {31'b0, v.rst});
    end else begin
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
    @(negedge clk);
    chk("post_v", {31'b0, cif.v_o}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{3'd1, 5'h0A, 8'h10, 1'b1, 1'b0, 12'h000, 1'b1};
    vecs[1] = '{3'd0, 5'h1F, 8'hFF, 1'b0, 1'b1, 12'h000, 1'b1};
    vecs[2] = '{3'd5, 5'h03, 8'h80, 1'b1, 1'b0, 12'h000, 1'b1};
    vecs[3] = '{3'd6, 5'h15, 8'h33, 1'b1, 1'b0, 12'h000, 1'b0};
    vecs[4] = '{3'd7, 5'h00, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0};
    vecs[5] = '{3'd2, 5'h11, 8'h5A, 1'b0, 1'b1, 12'hFFF, 1'b1};
    exp_drop = 0;

    // Reset with a stale toggle left high
    reset       = 1'b1;
    gpio        = 32'h0000_0001;
    tog         = 1'b1;
    cif.ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_v", {31'b0, cif.v_o}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_status", status, 32'h0);
    chk("rst_clk_id", {29'b0, cif.clk_id_o}, 32'h0);
    chk("rst_div", {24'b0, cif.div_o}, 32'h0);
    chk("rst_cmd_bits", {27'b0, cif.osc_o, cif.isDiv_o, cif.clk_reset_o},
        32'h0);
    reset = 1'b0;
    vc = 0;
    repeat (20) begin
      @(negedge clk);
      if (cif.v_o) vc++;
    end
    chk("prime_nofire", vc, 0);
    chk("prime_status", status, 32'h0);

    // First vector word must be the documented encoding (bit 31 aside)
    chk("enc_word", mk(vecs[0], 1'b0, 1'b0) & 32'h7FFF_FFFF, 32'h0002_20A2);

    for (int i = 0; i < 6; i++) send(vecs[i], 1'b0);

`ifdef BSG_GATEWAY_TAG_CMD_PARITY_EN
    send(vecs[0], 1'b1);
    send(vecs[1], 1'b0);
`endif

    repeat (2) @(negedge clk);
    chk("drop_status", status, stat(exp_drop, 0, 0));

    // Five back-to-back toggles with ready low: one overflows
    cif.ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tog  = ~tog;
      gpio = mk(mkv(3'(k)), tog, 1'b0);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("full_status", status, stat(exp_drop, 1, 4));
    chk("full_v", {31'b0, cif.v_o}, 32'h1);
    chk("full_busy", {31'b0, busy}, 32'h1);

    // Push lands on the same edge as a pop while full
    tog  = ~tog;
    gpio = mk(mkv(3'd5), tog, 1'b0);
    @(negedge clk);
    cif.ready_i = 1'b1;
    chk("pop_head", {29'b0, cif.clk_id_o}, 32'd0);
    @(negedge clk);
    cif.ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("pushpop_status", status, stat(exp_drop, 1, 4));

    // Drain in strict order
    exp_ids[0] = 3'd1;
    exp_ids[1] = 3'd2;
    exp_ids[2] = 3'd3;
    exp_ids[3] = 3'd5;
    cif.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_v", {31'b0, cif.v_o}, 32'h1);
      chk("drain_id", {29'b0, cif.clk_id_o}, {29'b0, exp_ids[i]});
      @(negedge clk);
    end
    chk("drain_empty_v", {31'b0, cif.v_o}, 32'h0);
    chk("drain_busy", {31'b0, busy}, 32'h0);

    // 300 illegal commands saturate the drop counter
    vc = 0;
    for (int k = 0; k < 300; k++) begin
      tog  = ~tog;
      gpio = mk(vecs[4], tog, 1'b0);
      @(negedge clk);
      if (cif.v_o) vc++;
    end
    repeat (4) begin
      @(negedge clk);
      if (cif.v_o) vc++;
    end
    chk("sat_nov", vc, 0);
    chk("sat_status", status, stat(255, 1, 0));

    // Reset with commands pending discards everything
    cif.ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tog  = ~tog;
      gpio = mk(mkv(3'(k)), tog, 1'b0);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("pend_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_v", {31'b0, cif.v_o}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    vc = 0;
    repeat (5) begin
      @(negedge clk);
      if (cif.v_o) vc++;
    end
    chk("mid_rst_nofire", vc, 0);
    chk("mid_rst_status", status, 32'h0);
    exp_drop = 0;
    cif.ready_i = 1'b1;
    send(vecs[2], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
